// File: rtl/uart_word_tx_if.sv
// rtl/uart_word_tx_if.sv - word handshake between a producing core and uart_word_tx
interface uart_word_tx_if #(
  parameter int BYTES = 4
);
  logic [8*BYTES-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - sends a captured multi-byte word as back-to-back UART frames, top byte first
module uart_word_tx #(
  parameter int FREQ      = 12000000,
  parameter int BAUD      = 9600,
  parameter int LIM       = FREQ / BAUD,
  parameter int BYTES     = 4,
  parameter int MSB_FIRST = 1,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          nrst,
  uart_word_tx_if.slave word,
  output logic          tx,
  output logic          busy,
  output logic          done,
  output logic [3:0]    byte_idx
);
  localparam int W  = 8 * BYTES;
  localparam int CW = (LIM > 1) ? $clog2(LIM) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(LIM - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(BYTES - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [W-1:0]  shreg;
  logic          ready_q;
  logic          baud_wrap;
  logic          next_bit;
  logic [W-1:0]  shreg_bit;
  logic [W-1:0]  shreg_byte;

  assign word.tx_ready = ready_q;
  assign baud_wrap     = (baud_cnt == BAUD_LAST);
  assign next_bit      = (MSB_FIRST != 0) ? shreg[W-1] : shreg[W-8];

  // LSB-first rotates only the top byte; the next byte is pulled up once the frame ends
  always_comb begin
    shreg_bit = shreg;
    if (MSB_FIRST != 0)
      shreg_bit = {shreg[W-2:0], 1'b1};
    else
      shreg_bit[W-1 -: 8] = {1'b1, shreg[W-1 -: 7]};
  end

  assign shreg_byte = (MSB_FIRST != 0) ? shreg : ((shreg << 8) | W'(8'hFF));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (word.tx_valid) begin
            shreg    <= word.tx_data;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            tx       <= 1'b0;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= next_bit;
            shreg    <= shreg_bit;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= next_bit;
              shreg   <= shreg_bit;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (byte_idx == LAST_BYTE) begin
                state    <= IDLE;
                done     <= 1'b1;
                ready_q  <= 1'b1;
                busy     <= 1'b0;
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + 4'd1;
                shreg    <= shreg_byte;
                tx       <= 1'b0;
                state    <= START;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - directed self-checking bench for uart_word_tx
module tb_uart_word_tx;
  localparam int L = 16;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  uart_word_tx_if #(.BYTES(4)) bus   ();
  uart_word_tx_if #(.BYTES(2)) bus_v ();
  uart_word_tx_if #(.BYTES(4)) bus_d ();

  logic       tx, busy, done;
  logic [3:0] byte_idx;
  logic       tx_v, busy_v, done_v;
  logic [3:0] byte_idx_v;
  logic       tx_d, busy_d, done_d;
  logic [3:0] byte_idx_d;

  uart_word_tx #(.FREQ(160), .BAUD(10), .BYTES(4), .MSB_FIRST(1), .STOP_BITS(1)) dut (
    .clk(clk), .nrst(nrst), .word(bus), .tx(tx), .busy(busy), .done(done), .byte_idx(byte_idx));

  uart_word_tx #(.FREQ(160), .BAUD(10), .BYTES(2), .MSB_FIRST(0), .STOP_BITS(2)) dut_v (
    .clk(clk), .nrst(nrst), .word(bus_v), .tx(tx_v), .busy(busy_v), .done(done_v), .byte_idx(byte_idx_v));

  uart_word_tx dut_d (
    .clk(clk), .nrst(nrst), .word(bus_d), .tx(tx_d), .busy(busy_d), .done(done_d), .byte_idx(byte_idx_d));

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 0) ? tx : tx_v;
  endfunction

  // Called just after the edge that starts a frame; samples each bit at its centre
  // and returns positioned just after the edge that starts the next frame.
  task automatic rx_frame(input int sel, input int lim, input int nbits, output logic [10:0] f);
    f = '0;
    for (int n = 0; n < nbits; n++) begin
      repeat ((n == 0) ? lim / 2 : lim) @(posedge clk);
      #1;
      f = {f[9:0], line(sel)};
    end
    repeat (lim - lim / 2) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic rx_word(input string tag, input logic [31:0] w);
    logic [10:0] f;
    logic [31:0] e;
    e = w;
    for (int j = 0; j < 4; j++) begin
      rx_frame(0, L, 10, f);
      check(tag, f, {2'b00, e[31:24], 1'b1});
      e = e << 8;
    end
  endtask

  initial begin
    logic [10:0] f;
    logic [31:0] e;
    int d0, n, t_rise, t_fall;

    bus.tx_data = '0;   bus.tx_valid = 1'b0;
    bus_v.tx_data = '0; bus_v.tx_valid = 1'b0;
    bus_d.tx_data = '0; bus_d.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", bus.tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_idx", byte_idx, 4'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // single word, MSB first
    d0 = done_cnt;
    send(32'h536E6170);
    check("t1_tx_start", tx, 1'b0);
    check("t1_ready_low", bus.tx_ready, 1'b0);
    check("t1_busy", busy, 1'b1);
    e = 32'h536E6170;
    for (int j = 0; j < 4; j++) begin
      rx_frame(0, L, 10, f);
      if (j == 0) check("t1_frame0_bits", f, 11'b00010100111);
      else        check("t1_frame", f, {2'b00, e[31:24], 1'b1});
      e = e << 8;
      if (j < 3) check("t1_byte_idx", byte_idx, 4'(j + 1));
    end
    check("t1_done", done, 1'b1);
    check("t1_ready_done", bus.tx_ready, 1'b1);
    check("t1_busy_done", busy, 1'b0);
    check("t1_idx_done", byte_idx, 4'd0);
    check("t1_tx_idle", tx, 1'b1);
    @(posedge clk);
    #1;
    check("t1_done_pulse", done, 1'b0);
    check("t1_done_count", done_cnt - d0, 1);

    // back-to-back with valid held high
    bus.tx_data  = 32'hA5A5A5A5;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_data = 32'h00FF00FF;
    rx_word("t2_word0", 32'hA5A5A5A5);
    check("t2_done", done, 1'b1);
    check("t2_ready", bus.tx_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    check("t2_second_start", tx, 1'b0);
    check("t2_done_clear", done, 1'b0);
    rx_word("t2_word1", 32'h00FF00FF);
    check("t2_done2", done, 1'b1);

    // inputs changing while busy must not disturb the captured word
    @(posedge clk);
    #1;
    send(32'h1B2D4E87);
    bus.tx_data = 32'hFFFFFFFF;
    e = 32'h1B2D4E87;
    for (int j = 0; j < 4; j++) begin
      bus.tx_valid = (j % 2 == 0);
      rx_frame(0, L, 10, f);
      check("t3_frame", f, {2'b00, e[31:24], 1'b1});
      e = e << 8;
      if (j < 3) check("t3_ready_low", bus.tx_ready, 1'b0);
    end
    check("t3_done", done, 1'b1);

    // reset during data bit 4 of byte 2
    @(posedge clk);
    #1;
    send(32'hDEADBEEF);
    rx_frame(0, L, 10, f);
    rx_frame(0, L, 10, f);
    repeat (4 * L + L / 2) @(posedge clk);
    #1;
    check("t4_idx_before", byte_idx, 4'd2);
    nrst = 1'b0;
    #1;
    check("t4_rst_tx", tx, 1'b1);
    check("t4_rst_ready", bus.tx_ready, 1'b1);
    check("t4_rst_idx", byte_idx, 4'd0);
    check("t4_rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    send(32'h12345678);
    rx_word("t4_after_rst", 32'h12345678);
    check("t4_done", done, 1'b1);

    // LSB first, two stop bits, two bytes
    bus_v.tx_data  = 16'h01A6;
    bus_v.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_v.tx_valid = 1'b0;
    check("t5_start", tx_v, 1'b0);
    check("t5_busy", busy_v, 1'b1);
    rx_frame(1, L, 11, f);
    check("t5_lsb_frame0", f, 11'b01000000011);
    check("t5_idx1", byte_idx_v, 4'd1);
    rx_frame(1, L, 11, f);
    check("t5_lsb_frame1", f, 11'b00110010111);
    check("t5_done", done_v, 1'b1);
    check("t5_ready", bus_v.tx_ready, 1'b1);

    // default parameters: 1250 clocks per bit
    bus_d.tx_data  = 32'h55555555;
    bus_d.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_d.tx_valid = 1'b0;
    n = 0;
    t_rise = -1;
    t_fall = -1;
    while (!done_d && n < 60000) begin
      @(posedge clk);
      #1;
      n++;
      if (t_rise < 0 && tx_d) t_rise = n;
      else if (t_rise >= 0 && t_fall < 0 && !tx_d) t_fall = n;
    end
    check("t6_done_seen", done_d, 1'b1);
    check("t6_first_rise", t_rise, 2500);
    check("t6_bit_period", t_fall - t_rise, 1250);
    check("t6_word_clocks", n, 50000);
    check("t6_ready", bus_d.tx_ready, 1'b1);
    check("t6_busy", busy_d, 1'b0);
    check("t6_idx", byte_idx_d, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serial transmitter that accepts a multi-byte word over a valid/ready handshake and sends it as consecutive 8N1-style UART frames, most-significant byte first. It is the transmit end for the team's UART word receiver: byte order, bit order and baud derivation match what that receiver assembles into its 32-bit store. It sits between a word-producing core and the `tx` pad.

## Interface
- `FREQ`, 12000000, clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s.
- `LIM`, FREQ/BAUD (1250), clocks per bit period; integer division, must be ≥ 2.
- `BYTES`, 4, bytes per word, 1..8.
- `MSB_FIRST`, 1, 1 = data bits sent bit7→bit0; 0 = bit0→bit7.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.

- `clk` in 1: clock.
- `nrst` in 1: reset; asynchronous, active-low.
- `tx_data` in 8*BYTES: word to send; byte `BYTES-1` (bits [8*BYTES-1 -: 8]) goes first.
- `tx_valid` in 1: word available.
- `tx_ready` out 1: block idle and accepting.
- `tx` out 1: serial line, idle high.
- `busy` out 1: transfer in progress (= !tx_ready).
- `done` out 1: one-cycle pulse at word completion.
- `byte_idx` out 4: index of the byte currently on the line (0 = first sent); 0 when idle.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `tx`=1, `tx_ready`=1. On `tx_valid && tx_ready` at a rising edge: capture `tx_data` into an internal shift register, clear baud counter, bit counter and `byte_idx`, go to START.
- START: `tx`=0 for LIM clocks, then DATA.
- DATA: 8 bits, each held LIM clocks. MSB_FIRST=1 sends shift-register bit [8*BYTES-1] and shifts left by 1 (filling 1); MSB_FIRST=0 sends the LSB of the current top byte. After bit 8, go to STOP.
- STOP: `tx`=1 for STOP_BITS*LIM clocks. Then, if `byte_idx` = BYTES-1, go to IDLE and pulse `done`. Otherwise increment `byte_idx` and go to START. There is no idle gap between bytes of one word.
- Baud counter width is $clog2(LIM). It counts 0..LIM-1 and wraps; the bit advances on wrap. The counter is cleared on every state entry.
- `tx_data` and `tx_valid` are ignored outside IDLE; the captured copy is the only source. A word is never partially re-sent.
- All outputs are registered. `tx` has no combinational path from inputs.

## Timing
- Reset (async, nrst low): state IDLE, `tx`=1, `tx_ready`=1, `busy`=0, `done`=0, `byte_idx`=0, counters 0, shift register 0. Reset mid-frame aborts immediately. `tx` returns high and the word is lost.
- Handshake at edge k: `tx`=0 and `tx_ready`=0 from edge k+1.
- Per byte: (9+STOP_BITS)*LIM clocks. Per word: BYTES*(9+STOP_BITS)*LIM clocks, measured from edge k+1 to the first IDLE cycle.
- `done`=1 in exactly the first IDLE cycle after the final stop bit. `tx_ready`=1 in that same cycle.
- Back-to-back: if `tx_valid` is high in the `done` cycle, the next start bit begins on the following edge. The inter-word gap is therefore 0 extra clocks beyond the stop bit(s).
- `byte_idx` updates at each STOP→START transition and resets to 0 on entering IDLE.

## Test plan
- Single word, LIM=16 (FREQ=160, BAUD=10), `tx_data`=0x536E6170. Sample `tx` at bit centres. Required: frames 0x53, 0x6E, 0x61, 0x70 in that order, MSB-first. First frame bits are 0,0,1,0,1,0,0,1,1,1 (start, data, stop). `done` pulses once, 640 clocks after handshake+1.
- Back-to-back: two words 0xA5A5A5A5 then 0x00FF00FF, `tx_valid` held high. Required: second start bit begins exactly 1 clock after `done`. Total 1280 clocks. No glitch high-width <16 between words.
- Valid while busy: change `tx_data` to 0xFFFFFFFF and toggle `tx_valid` mid-word. Required: line still carries the originally captured word, and `tx_ready` stays 0 until `done`.
- Reset mid-frame: assert nrst low during bit 4 of byte 2. Required: `tx`=1, `tx_ready`=1, `byte_idx`=0 immediately. After release, a new word 0x12345678 transmits correctly.
- Variants: MSB_FIRST=0 with 0x01 in the top byte gives data bits 1,0,0,0,0,0,0,0. STOP_BITS=2 gives byte period 11*LIM and `tx` high for 32 clocks between frames.
- Default parameters (LIM=1250), one word: bit period exactly 1250 clocks. Word duration 50000 clocks.
